// File: rtl/p2s_pkg.sv
// ============================================================================
// Module      : p2s_pkg
// Description : Shared constants and state encoding for par_to_serial_tx.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package p2s_pkg;

    localparam logic [7:0] IDLE_SYM  = 8'hBC;
    localparam int         BIT_CNT_W = 3;

    typedef enum logic [0:0] {
        ST_PREAMBLE = 1'b0,
        ST_ACTIVE   = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/par_to_serial_tx_if.sv
// ============================================================================
// Module      : par_to_serial_tx_if
// Description : Byte valid/ready handshake between a producer and the
//               serial transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface par_to_serial_tx_if;
    logic [7:0] data_in;
    logic       valid_in;
    logic       ready_out;

    modport master (output data_in, output valid_in, input ready_out);
    modport slave  (input data_in, input valid_in, output ready_out);
endinterface

`default_nettype wire

// File: rtl/p2s_shifter.sv
// ============================================================================
// Module      : p2s_shifter
// Description : 8-bit MSB-first shifter with bit counter and symbol boundary.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module p2s_shifter
    import p2s_pkg::*;
(
    input  wire logic       clk_32f,
    input  wire logic       reset,
    input  wire logic       load_i,
    input  wire logic [7:0] sym_i,
    output logic            boundary_o,
    output logic            data_o,
    output logic            byte_start_o
);

    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [6:0]           shift_q, shift_d;
    logic                 data_q, data_d;
    logic                 bs_q, bs_d;

    // Counter resets to the last bit position so edge 1 is a symbol boundary.
    assign boundary_o = (bit_cnt_q == BIT_CNT_W'(7));

    always_comb begin
        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
        shift_d   = {shift_q[5:0], 1'b0};
        data_d    = shift_q[6];
        bs_d      = 1'b0;
        if (load_i) begin
            bit_cnt_d = '0;
            shift_d   = sym_i[6:0];
            data_d    = sym_i[7];
            bs_d      = 1'b1;
        end
    end

    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            bit_cnt_q <= BIT_CNT_W'(7);
            shift_q   <= '0;
            data_q    <= 1'b0;
            bs_q      <= 1'b0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            bs_q      <= bs_d;
        end
    end

    assign data_o       = data_q;
    assign byte_start_o = bs_q;

endmodule

`default_nettype wire

// File: rtl/par_to_serial_tx.sv
// ============================================================================
// Module      : par_to_serial_tx
// Description : Byte-to-bitstream transmitter with one-entry holding register
//               and 0xBC idle fill. Define P2S_PREAMBLE_EN for a post-reset
//               preamble of PREAMBLE_LEN idle symbols.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module par_to_serial_tx
    import p2s_pkg::*;
#(
    parameter int PREAMBLE_LEN = 4
)(
    input  wire logic         clk_32f,
    input  wire logic         reset,
    par_to_serial_tx_if.slave bus,
    output logic              data_out,
    output logic              byte_start,
    output logic              idle_out
);

    generate
        if (PREAMBLE_LEN < 1 || PREAMBLE_LEN > 15) begin : g_bad_preamble_len
            $error("PREAMBLE_LEN must be in 1..15");
        end
    endgenerate

    logic       w_boundary;
    logic       w_take_hold;
    logic       w_accept;
    logic [7:0] w_sym;
    logic       w_sym_idle;
    state_t     state_q;
    logic [7:0] hold_q, hold_d;
    logic       hold_full_q, hold_full_d;
    logic       idle_q, idle_d;

`ifdef P2S_PREAMBLE_EN
    state_t     state_d;
    logic [3:0] pre_cnt_q, pre_cnt_d;

    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            state_q   <= ST_PREAMBLE;
            pre_cnt_q <= 4'd0;
        end else begin
            state_q   <= state_d;
            pre_cnt_q <= pre_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pre_cnt_d = pre_cnt_q;
        if (w_boundary && state_q == ST_PREAMBLE) begin
            pre_cnt_d = pre_cnt_q + 4'd1;
            if (pre_cnt_d == 4'(PREAMBLE_LEN))
                state_d = ST_ACTIVE;
        end
    end
`else
    assign state_q = ST_ACTIVE;
`endif

    // Symbol selection; the hold byte is only consumed once the link is active.
    always_comb begin
        w_take_hold = w_boundary && (state_q == ST_ACTIVE) && hold_full_q;
        w_sym       = w_take_hold ? hold_q : IDLE_SYM;
        w_sym_idle  = ~w_take_hold;
    end

    // Accept and consume are mutually exclusive because ready_out mirrors ~hold_full.
    assign w_accept = bus.valid_in && ~hold_full_q;

    always_comb begin
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        idle_d      = idle_q;
        if (w_take_hold)
            hold_full_d = 1'b0;
        if (w_accept) begin
            hold_d      = bus.data_in;
            hold_full_d = 1'b1;
        end
        if (w_boundary)
            idle_d = w_sym_idle;
    end

    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            hold_q      <= 8'h00;
            hold_full_q <= 1'b0;
            idle_q      <= 1'b1;
        end else begin
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            idle_q      <= idle_d;
        end
    end

    p2s_shifter u_shifter (
        .clk_32f      (clk_32f),
        .reset        (reset),
        .load_i       (w_boundary),
        .sym_i        (w_sym),
        .boundary_o   (w_boundary),
        .data_o       (data_out),
        .byte_start_o (byte_start)
    );

    assign bus.ready_out = ~hold_full_q;
    assign idle_out      = idle_q;

endmodule

`default_nettype wire

// File: tb/tb_par_to_serial_tx.sv
// ============================================================================
// Module      : tb_par_to_serial_tx
// Description : Self-checking bench for par_to_serial_tx; symbol-level model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_par_to_serial_tx;
    import p2s_pkg::*;

`ifdef P2S_PREAMBLE_EN
    localparam int PRE = 4;
`else
    localparam int PRE = 0;
`endif
    localparam int FIRST_DATA_EDGE = (8 * PRE + 1 > 9) ? 8 * PRE + 1 : 9;

    logic clk_32f = 1'b0;
    logic reset   = 1'b1;
    logic data_out, byte_start, idle_out;

    par_to_serial_tx_if bus ();

    par_to_serial_tx #(.PREAMBLE_LEN(4)) dut (
        .clk_32f    (clk_32f),
        .reset      (reset),
        .bus        (bus),
        .data_out   (data_out),
        .byte_start (byte_start),
        .idle_out   (idle_out)
    );

    always #5 clk_32f = ~clk_32f;

    // Symbol-level reference model state
    int         m_edge, m_pre_sent, m_pos;
    bit         m_full, m_idle, m_acc;
    logic [7:0] m_hold, m_sym;
    logic [3:0] exp_v;
    logic [7:0] acc_q[$];
    logic [7:0] rx_q[$];
    int         n_pass, n_total;

    // Bench-side deserializer collecting completed data symbols
    int         rx_n = 0;
    logic [7:0] rx_sh;
    bit         rx_idle;
    always @(negedge clk_32f) begin
        if (reset) begin
            rx_n = 0;
        end else begin
            if (byte_start) begin
                rx_n = 1; rx_sh = {7'b0, data_out}; rx_idle = idle_out;
            end else if (rx_n > 0) begin
                rx_sh = {rx_sh[6:0], data_out}; rx_n++;
            end
            if (rx_n == 8) begin
                if (!rx_idle) rx_q.push_back(rx_sh);
                rx_n = 0;
            end
        end
    end

    task automatic model_reset();
        m_edge = 0; m_pre_sent = 0; m_pos = 7; m_full = 0; m_idle = 1; m_acc = 0;
        m_sym = IDLE_SYM; exp_v = 4'b0011;
        acc_q.delete(); rx_q.delete();
    endtask

    task automatic do_reset();
        bus.valid_in = 1'b0;
        bus.data_in  = 8'h00;
        #2 reset = 1'b1;
        @(negedge clk_32f);
        @(negedge clk_32f);
        model_reset();
        reset = 1'b0;
    endtask

    // Advance one clock; model evaluates the edge from the inputs the bench drove.
    task automatic step();
        bit acc, bnd;
        @(posedge clk_32f);
        acc = bus.valid_in && !m_full;
        m_edge++;
        bnd = ((m_edge - 1) % 8) == 0;
        if (bnd) begin
            m_pos = 0;
            if (m_pre_sent < PRE) begin
                m_sym = IDLE_SYM; m_idle = 1; m_pre_sent++;
            end else if (m_full) begin
                m_sym = m_hold; m_idle = 0; m_full = 0;
            end else begin
                m_sym = IDLE_SYM; m_idle = 1;
            end
        end else begin
            m_pos++;
        end
        if (acc) begin
            m_hold = bus.data_in; m_full = 1; acc_q.push_back(bus.data_in);
        end
        m_acc = acc;
        exp_v = {m_sym[7 - m_pos], bnd, m_idle, !m_full};
        @(negedge clk_32f);
    endtask

    task automatic test_reset();
        do_reset();
        n_total++;
        if (data_out !== 1'b0) $display("FAIL reset_data_out: got %b expected 0", data_out);
        else n_pass++;
        n_total++;
        if (byte_start !== 1'b0) $display("FAIL reset_byte_start: got %b expected 0", byte_start);
        else n_pass++;
        n_total++;
        if (idle_out !== 1'b1) $display("FAIL reset_idle_out: got %b expected 1", idle_out);
        else n_pass++;
        n_total++;
        if (bus.ready_out !== 1'b1) $display("FAIL reset_ready_out: got %b expected 1", bus.ready_out);
        else n_pass++;
    endtask

    task automatic test_preamble();
        logic [47:0] bits, want;
        int n_bs = 0;
        want = {6{8'hBC}};
        do_reset();
        for (int i = 0; i < 48; i++) begin
            step();
            bits = {bits[46:0], data_out};
            if (byte_start) n_bs++;
            n_total++;
            if ({data_out, byte_start, idle_out, bus.ready_out} !== exp_v)
                $display("FAIL preamble edge %0d: got {dout,bs,idle,rdy}=%b expected %b",
                         m_edge, {data_out, byte_start, idle_out, bus.ready_out}, exp_v);
            else n_pass++;
        end
        n_total++;
        if (bits !== want) $display("FAIL preamble_stream: got %h expected %h", bits, want);
        else n_pass++;
        n_total++;
        if (n_bs != 6) $display("FAIL preamble_byte_starts: got %0d expected 6", n_bs);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [3];
        int idx = 0;
        int data_edges[$];
        bytes = '{8'hFF, 8'hEE, 8'hDD};
        do_reset();
        for (int i = 0; i < 8 * (PRE + 5); i++) begin
            bus.valid_in = (idx < 3);
            bus.data_in  = (idx < 3) ? bytes[idx] : 8'h00;
            step();
            if (m_acc) idx++;
            if (byte_start && !idle_out) data_edges.push_back(m_edge);
            n_total++;
            if ({data_out, byte_start, idle_out, bus.ready_out} !== exp_v)
                $display("FAIL b2b edge %0d: got {dout,bs,idle,rdy}=%b expected %b",
                         m_edge, {data_out, byte_start, idle_out, bus.ready_out}, exp_v);
            else n_pass++;
        end
        n_total++;
        if (data_edges.size() != 3 || data_edges[0] != FIRST_DATA_EDGE ||
            data_edges[1] != FIRST_DATA_EDGE + 8 || data_edges[2] != FIRST_DATA_EDGE + 16)
            $display("FAIL b2b_msb_edges: got %p expected first at %0d spaced by 8",
                     data_edges, FIRST_DATA_EDGE);
        else n_pass++;
        n_total++;
        if (rx_q.size() != 3 || rx_q[0] !== 8'hFF || rx_q[1] !== 8'hEE || rx_q[2] !== 8'hDD)
            $display("FAIL b2b_bytes: got %p expected FF EE DD", rx_q);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        int first_edge = -1;
        do_reset();
        bus.valid_in = 1'b1;
        bus.data_in  = 8'hAA;
        for (int i = 0; i < 8 * PRE + 24; i++) begin
            step();
            if (acc_q.size() >= 1) bus.valid_in = 1'b0;
            if (byte_start && !idle_out && first_edge < 0) first_edge = m_edge;
            n_total++;
            if ({data_out, byte_start, idle_out, bus.ready_out} !== exp_v)
                $display("FAIL backpressure edge %0d: got {dout,bs,idle,rdy}=%b expected %b",
                         m_edge, {data_out, byte_start, idle_out, bus.ready_out}, exp_v);
            else n_pass++;
        end
        n_total++;
        if (first_edge != FIRST_DATA_EDGE)
            $display("FAIL backpressure_msb_edge: got %0d expected %0d", first_edge, FIRST_DATA_EDGE);
        else n_pass++;
        n_total++;
        if (rx_q.size() != 1 || rx_q[0] !== 8'hAA)
            $display("FAIL backpressure_bytes: got %p expected AA", rx_q);
        else n_pass++;
    endtask

    task automatic test_random();
        bit ok;
        do_reset();
        for (int i = 0; i < 8 * PRE + 400; i++) begin
            bus.valid_in = (i < 8 * PRE + 370) ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.data_in  = 8'($urandom);
            step();
            n_total++;
            if ({data_out, byte_start, idle_out, bus.ready_out} !== exp_v)
                $display("FAIL random edge %0d: got {dout,bs,idle,rdy}=%b expected %b",
                         m_edge, {data_out, byte_start, idle_out, bus.ready_out}, exp_v);
            else n_pass++;
        end
        ok = (rx_q.size() == acc_q.size()) && (acc_q.size() > 0);
        for (int k = 0; ok && k < acc_q.size(); k++)
            if (rx_q[k] !== acc_q[k]) ok = 0;
        n_total++;
        if (!ok) $display("FAIL random_order: got %0d bytes expected %0d in order",
                          rx_q.size(), acc_q.size());
        else n_pass++;
    endtask

    task automatic test_reset_mid_byte();
        bit found = 0;
        do_reset();
        bus.valid_in = 1'b1;
        bus.data_in  = 8'hAA;
        for (int i = 0; i < 8 * PRE + 40 && !found; i++) begin
            step();
            if (m_acc) bus.valid_in = 1'b0;
            if (!m_idle && m_pos == 4) found = 1;
        end
        n_total++;
        if (!found) $display("FAIL midreset_reach_bit4: got timeout expected AA bit 4");
        else n_pass++;
        n_total++;
        if (data_out !== 1'b1) $display("FAIL midreset_pre_bit: got %b expected 1", data_out);
        else n_pass++;
        #2 reset = 1'b1;
        #1;
        n_total++;
        if ({data_out, byte_start, idle_out, bus.ready_out} !== 4'b0011)
            $display("FAIL midreset_async: got {dout,bs,idle,rdy}=%b expected 0011",
                     {data_out, byte_start, idle_out, bus.ready_out});
        else n_pass++;
        @(negedge clk_32f);
        model_reset();
        reset = 1'b0;
        for (int i = 0; i < 8 * (PRE + 2); i++) begin
            step();
            n_total++;
            if ({data_out, byte_start, idle_out, bus.ready_out} !== exp_v)
                $display("FAIL midreset edge %0d: got {dout,bs,idle,rdy}=%b expected %b",
                         m_edge, {data_out, byte_start, idle_out, bus.ready_out}, exp_v);
            else n_pass++;
        end
        n_total++;
        if (rx_q.size() != 0) $display("FAIL midreset_hold_discarded: got %0d data bytes expected 0",
                                       rx_q.size());
        else n_pass++;
    endtask

    initial begin
        n_pass = 0; n_total = 0;
        bus.valid_in = 1'b0;
        bus.data_in  = 8'h00;
        model_reset();
        @(negedge clk_32f);
        test_reset();
        test_preamble();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_reset_mid_byte();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
